// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 exception/interrupt unit placed beside the M stage.
// Holds SR/Cause/EPC/PRId and latches the hardware interrupt lines. It
// arbitrates interrupt > exception > eret and issues a one-cycle flush
// with a redirect PC. After each redirect a one-cycle FLUSH state ignores
// the bubble that sits in M.
// Optional build macro CP0_TIMER_EN adds Count(9)/Compare(11) and a timer
// interrupt on SR/Cause bit 15.
module cp0_exc_unit #(
  parameter int          NUM_HWINT    = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h4C57_0002
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          PCM,
  input  logic                 bdM,
  input  logic [4:0]           ExcCodeM,
  input  logic                 eretM,
  input  logic                 mtc0M,
  input  logic [4:0]           AddrM,
  input  logic [31:0]          DinM,
  input  logic [NUM_HWINT-1:0] HWInt,
  output logic                 ExcFlush,
  output logic [31:0]          NPCExc,
  output logic [31:0]          EPC,
  output logic                 EXL,
  output logic [31:0]          Dout
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]           state;
  logic [NUM_HWINT-1:0] sr_im, cause_ip;
  logic                 sr_exl, sr_ie, cause_bd;
  logic [1:0]           cause_sw;
  logic [4:0]           cause_exc;
  logic [31:2]          epc_q;
  logic                 tm_mask, tm_pend;
  logic                 run, int_req, take_exc, take_eret, do_mtc0;
  logic [31:0]          epc_new, sr_val, cause_val;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q;

  // Free-running Count, loadable Compare, sticky pending bit cleared by a Compare write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= '0;
      compare_q <= '0;
      tm_pend   <= 1'b0;
      tm_mask   <= 1'b0;
    end else begin
      count_q <= (do_mtc0 && AddrM == 5'd9) ? DinM : count_q + 32'd1;
      if (do_mtc0 && AddrM == 5'd11) begin
        compare_q <= DinM;
        tm_pend   <= 1'b0;
      end else if (count_q == compare_q) begin
        tm_pend <= 1'b1;
      end
      if (do_mtc0 && AddrM == 5'd12) tm_mask <= DinM[15];
    end
  end
`else
  assign tm_mask = 1'b0;
  assign tm_pend = 1'b0;
`endif

  // A redirect needs IE set and EXL clear for interrupts; exceptions ignore EXL
  assign run       = (state == RUN);
  assign int_req   = sr_ie & ~sr_exl & ((|(cause_ip & sr_im)) | (tm_mask & tm_pend));
  assign take_exc  = run & (int_req | (ExcCodeM != 5'd0));
  assign take_eret = run & ~take_exc & eretM;
  assign do_mtc0   = run & ~take_exc & ~eretM & mtc0M;
  assign epc_new   = bdM ? (PCM - 32'd4) : PCM;

  assign ExcFlush  = ~Reset & (take_exc | take_eret);
  assign NPCExc    = take_exc ? HANDLER_ADDR : {epc_q, 2'b00};
  assign EPC       = {epc_q, 2'b00};
  assign EXL       = sr_exl;

  // Assemble architectural views; timer bit 15 is ORed so it can share IM7/IP7
  always_comb begin
    sr_val                 = '0;
    sr_val[10 +: NUM_HWINT] = sr_im;
    sr_val[15]             = sr_val[15] | tm_mask;
    sr_val[1]              = sr_exl;
    sr_val[0]              = sr_ie;
    cause_val                 = '0;
    cause_val[31]             = cause_bd;
    cause_val[10 +: NUM_HWINT] = cause_ip;
    cause_val[15]             = cause_val[15] | tm_pend;
    cause_val[9:8]            = cause_sw;
    cause_val[6:2]            = cause_exc;
  end

  // mfc0 read port: reflects pre-edge state, so a same-cycle mtc0 is not visible
  always_comb begin
    Dout = '0;
    case (AddrM)
      5'd12: Dout = sr_val;
      5'd13: Dout = cause_val;
      5'd14: Dout = {epc_q, 2'b00};
      5'd15: Dout = PRID;
`ifdef CP0_TIMER_EN
      5'd9:  Dout = count_q;
      5'd11: Dout = compare_q;
`endif
      default: Dout = '0;
    endcase
  end

  // Register updates: exception/interrupt > eret > mtc0; IP sampled every cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RUN;
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_sw  <= '0;
      cause_exc <= '0;
      epc_q     <= '0;
    end else begin
      cause_ip <= HWInt;
      state    <= RUN;
      if (take_exc) begin
        state     <= FLUSH;
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCodeM;
        cause_bd  <= bdM;
        epc_q     <= epc_new[31:2];
      end else if (take_eret) begin
        state  <= FLUSH;
        sr_exl <= 1'b0;
      end else if (do_mtc0) begin
        case (AddrM)
          5'd12: begin
            sr_im  <= DinM[10 +: NUM_HWINT];
            sr_exl <= DinM[1];
            sr_ie  <= DinM[0];
          end
          5'd13: cause_sw <= DinM[9:8];
          5'd14: epc_q    <= DinM[31:2];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed walk through the main scenarios followed by
// randomized traffic, all checked against a register-image model.
module tb_cp0_exc_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCM, DinM;
  logic        bdM, eretM, mtc0M;
  logic [4:0]  ExcCodeM, AddrM;
  logic [5:0]  HWInt;
  logic        ExcFlush, EXL;
  logic [31:0] NPCExc, EPC, Dout;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  cp0_exc_unit dut (
    .Clk(Clk), .Reset(Reset), .PCM(PCM), .bdM(bdM), .ExcCodeM(ExcCodeM),
    .eretM(eretM), .mtc0M(mtc0M), .AddrM(AddrM), .DinM(DinM), .HWInt(HWInt),
    .ExcFlush(ExcFlush), .NPCExc(NPCExc), .EPC(EPC), .EXL(EXL), .Dout(Dout)
  );

  // Model: 32-bit images of SR/Cause/EPC plus a "bubble in M" flag
  localparam logic [31:0] IMASK = 32'h0000_FC00;
  logic [31:0] m_sr, m_cause, m_epc;
  bit          m_flush, m_known;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge
  task automatic step(input bit rst, input logic [31:0] pc, input bit bd, input logic [4:0] exc,
                      input bit er, input bit mt, input logic [4:0] ad, input logic [31:0] din,
                      input logic [5:0] hw);
    bit irq, flush_e;
    logic [31:0] npc_e, dout_e;
    Reset = rst; PCM = pc; bdM = bd; ExcCodeM = exc; eretM = er;
    mtc0M = mt; AddrM = ad; DinM = din; HWInt = hw;
    irq     = m_sr[0] && !m_sr[1] && ((m_cause & m_sr & IMASK) != 0);
    flush_e = !rst && !m_flush && (irq || exc != 0 || er);
    npc_e   = (irq || exc != 0) ? 32'h0000_4180 : m_epc;
    case (ad)
      5'd12:   dout_e = m_sr;
      5'd13:   dout_e = m_cause;
      5'd14:   dout_e = m_epc;
      5'd15:   dout_e = 32'h4C57_0002;
      default: dout_e = 32'h0;
    endcase
    #1;
    if (m_known) begin
      chk("flush", {31'b0, ExcFlush}, {31'b0, flush_e});
      if (flush_e) chk("npc", NPCExc, npc_e);
      chk("dout", Dout, dout_e);
      chk("epc", EPC, m_epc);
      chk("exl", {31'b0, EXL}, {31'b0, m_sr[1]});
    end
    @(posedge Clk);
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_flush = 0; m_known = 1;
    end else begin
      if (m_flush) m_flush = 0;
      else if (irq || exc != 0) begin
        m_sr[1]      = 1'b1;
        m_cause[6:2] = irq ? 5'd0 : exc;
        m_cause[31]  = bd;
        m_epc        = (bd ? pc - 32'd4 : pc) & ~32'h3;
        m_flush      = 1;
      end else if (er) begin
        m_sr[1] = 1'b0;
        m_flush = 1;
      end else if (mt) begin
        case (ad)
          5'd12: m_sr    = din & (IMASK | 32'h3);
          5'd13: m_cause = (m_cause & ~32'h300) | (din & 32'h300);
          5'd14: m_epc   = din & ~32'h3;
          default: ;
        endcase
      end
      m_cause = (m_cause & ~IMASK) | ({26'b0, hw} << 10);
    end
    @(negedge Clk);
  endtask

  logic [4:0] addr_tab [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

  initial begin
    logic [5:0]  hw;
    logic [31:0] din;
    m_sr = 0; m_cause = 0; m_epc = 0; m_flush = 0; m_known = 0;
    @(negedge Clk);
    step(1, 0, 0, 0, 0, 0, 12, 0, 0);
    step(1, 0, 0, 0, 0, 0, 12, 0, 0);
    // Reset values
    step(0, 0, 0, 0, 0, 0, 12, 0, 0);  chk("rst_sr", Dout, 32'h0);
    step(0, 0, 0, 0, 0, 0, 13, 0, 0);  chk("rst_cause", Dout, 32'h0);
    chk("rst_exl", {31'b0, EXL}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 14, 0, 0);  chk("rst_epc", Dout, 32'h0);
    step(0, 0, 0, 0, 0, 0, 15, 0, 0);  chk("prid", Dout, 32'h4C57_0002);
    chk("rst_flush", {31'b0, ExcFlush}, 32'h0);
    // Synchronous exception, then FLUSH ignores a held ExcCode
    step(0, 32'h3010, 0, 4, 0, 0, 13, 0, 0);
    chk("exc_epc", EPC, 32'h3010);
    chk("exc_cause", Dout, 32'h0000_0010);
    chk("exc_exl", {31'b0, EXL}, 32'h1);
    chk("flush_sup", {31'b0, ExcFlush}, 32'h0);
    step(0, 32'h3010, 0, 4, 0, 0, 13, 0, 0);
    // Exception in a delay slot while EXL=1
    step(0, 32'h3024, 1, 12, 0, 0, 13, 0, 0);
    chk("bd_epc", EPC, 32'h3020);
    chk("bd_cause", {31'b0, Dout[31]}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Interrupt path
    step(0, 0, 0, 0, 0, 1, 12, 32'h0000_FC01, 0);
    chk("sr_wr", Dout, 32'h0000_FC01);
    step(0, 0, 0, 0, 0, 0, 13, 0, 6'b000100);
    chk("irq_flush", {31'b0, ExcFlush}, 32'h1);
    chk("irq_npc", NPCExc, 32'h0000_4180);
    step(0, 32'h3040, 0, 10, 0, 0, 13, 0, 6'b000100);
    chk("irq_cause", Dout, 32'h0000_1000);
    chk("irq_exl", {31'b0, EXL}, 32'h1);
    chk("irq_epc", EPC, 32'h3040);
    step(0, 0, 0, 0, 0, 0, 13, 0, 6'b000100);
    // eret back, interrupt re-taken right after FLUSH
    step(0, 0, 0, 0, 1, 0, 0, 0, 6'b000100);
    chk("eret_exl", {31'b0, EXL}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'b000100);
    chk("retake", {31'b0, ExcFlush}, 32'h1);
    step(0, 32'h3050, 0, 0, 0, 0, 0, 0, 6'b000100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mtc0 dropped against an exception, then a lone write
    step(0, 32'h3040, 0, 4, 0, 1, 14, 32'h3013, 0);
    chk("mtc0_drop", EPC, 32'h3040);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 14, 32'h3013, 0);
    chk("mtc0_epc", EPC, 32'h3010);
    // Reset while in FLUSH
    step(0, 32'h3060, 0, 4, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4, 1, 1, 14, 32'h5555, 0);
    chk("rst_mid_exl", {31'b0, EXL}, 32'h0);
    chk("rst_mid_epc", EPC, 32'h0);
    // Randomized traffic
    hw = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) hw = 6'($urandom);
      din = $urandom;
      if ($urandom_range(1) == 0) din[1:0] = 2'b01;
      step($urandom_range(99) < 2, $urandom, 1'($urandom_range(1)),
           ($urandom_range(5) == 0) ? 5'($urandom_range(31, 1)) : 5'd0,
           $urandom_range(7) == 0, $urandom_range(2) == 0,
           addr_tab[$urandom_range(6)], din, hw);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
